// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: sticky edge capture with W1C clear and level irq; PIO_IN_SYNC_EN adds a 2-flop input synchroniser.
// Read latency 1 cycle; slave is always ready, so there is no backpressure.
module pio_in_edge_irq #(
  parameter int WIDTH     = 1,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr_bits;
  logic [1:0]       prime_cnt;
  logic             capture_en;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_wd;

`ifdef PIO_IN_SYNC_EN
  localparam logic [1:0] PRIME = 2'd3;

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= in_port;
      sync_q    <= sync_meta;
    end
  end

  assign s = sync_q;
`else
  localparam logic [1:0] PRIME = 2'd1;

  assign s = in_port;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= s;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = s & ~prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~s & prev;
    end else begin : g_any
      assign edge_det = s ^ prev;
    end
  endgenerate

  // Capture stays off until the zero-reset pipeline holds real samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= 2'd0;
    end else if (prime_cnt != PRIME) begin
      prime_cnt <= prime_cnt + 2'd1;
    end
  end

  assign capture_en = (prime_cnt == PRIME);
  assign wr_en      = chipselect & ~write_n;
  assign clr_bits   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_en && address == ADDR_MASK) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Set beats clear so an edge landing on a W1C write is never dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else if (capture_en) begin
      edgecapture <= (edgecapture & ~clr_bits) | edge_det;
    end else begin
      edgecapture <= edgecapture & ~clr_bits;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = s;
      ADDR_MASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edgecapture;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edgecapture & irqmask);

  assign unused_wd = ^writedata;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: rising-edge and any-edge instances share one bus and input port.
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0;
  logic [31:0] rd2;
  logic        irq0;
  logic        irq2;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2)
  );

  typedef struct {
    logic [31:0] rd0;
    logic        irq0;
    logic [31:0] rd2;
    logic        irq2;
  } exp_t;

  typedef struct {
    logic [1:0]  a;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [31:0] rd0;
    logic        irq0;
    logic [31:0] rd2;
    logic        irq2;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives one bus cycle and checks the outputs after the next rising edge.
  task automatic step(input string name, input logic [1:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [7:0] inp,
                      input logic [31:0] e_rd0, input logic e_irq0,
                      input logic [31:0] e_rd2, input logic e_irq2);
    exp_t e;
    exp_t x;
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    in_port    = inp;
    e.rd0 = e_rd0; e.irq0 = e_irq0; e.rd2 = e_rd2; e.irq2 = e_irq2;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    check32({name, " rd0"}, rd0, x.rd0);
    check1({name, " irq0"}, irq0, x.irq0);
    check32({name, " rd2"}, rd2, x.rd2);
    check1({name, " irq2"}, irq2, x.irq2);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hFF;
    #1;
    check32("reset rd0", rd0, 32'h0);
    check1("reset irq0", irq0, 1'b0);
    check32("reset rd2", rd2, 32'h0);
    check1("reset irq2", irq2, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Line held high through reset must not produce a capture.
    for (int i = 0; i < 10; i++)
      step("prime", 2'd3, 1'b0, 1'b1, 32'h0, 8'hFF, 32'h0, 1'b0, 32'h0, 1'b0);
    step("data_ff", 2'd0, 1'b0, 1'b1, 32'h0, 8'hFF, 32'hFF, 1'b0, 32'hFF, 1'b0);

`ifdef PIO_IN_SYNC_EN
    step("sync1", 2'd0, 1'b0, 1'b1, 32'h0, 8'hA5, 32'hFF, 1'b0, 32'hFF, 1'b0);
    step("sync2", 2'd0, 1'b0, 1'b1, 32'h0, 8'hA5, 32'hFF, 1'b0, 32'hFF, 1'b0);
    step("sync3", 2'd0, 1'b0, 1'b1, 32'h0, 8'hA5, 32'hA5, 1'b0, 32'hA5, 1'b0);
    step("rsvd",  2'd1, 1'b0, 1'b1, 32'h0, 8'hA5, 32'h0,  1'b0, 32'h0,  1'b0);
    step("sync4", 2'd0, 1'b0, 1'b1, 32'h0, 8'hA5, 32'hA5, 1'b0, 32'hA5, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check32("midrst rd0", rd0, 32'h0);
    check32("midrst rd2", rd2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
`else
    //                a      cs    wn    wd             in     rd0    irq0  rd2    irq2
    vecs.push_back('{2'd2, 1'b1, 1'b0, 32'h01,       8'hFF, 32'h00, 1'b0, 32'h00, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFE, 32'h00, 1'b0, 32'h00, 1'b1});
    vecs.push_back('{2'd3, 1'b1, 1'b0, 32'h01,       8'hFE, 32'h00, 1'b0, 32'h01, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFF, 32'h00, 1'b1, 32'h00, 1'b1});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFF, 32'h01, 1'b1, 32'h01, 1'b1});
    vecs.push_back('{2'd3, 1'b1, 1'b0, 32'h01,       8'hFF, 32'h01, 1'b0, 32'h01, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFF, 32'h00, 1'b0, 32'h00, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFB, 32'h00, 1'b0, 32'h00, 1'b0});
    vecs.push_back('{2'd3, 1'b1, 1'b0, 32'h04,       8'hFF, 32'h00, 1'b0, 32'h04, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFF, 32'h04, 1'b0, 32'h04, 1'b0});
    vecs.push_back('{2'd3, 1'b1, 1'b0, 32'hFF,       8'hFF, 32'h04, 1'b0, 32'h04, 1'b0});
    vecs.push_back('{2'd2, 1'b1, 1'b0, 32'h00,       8'hFF, 32'h01, 1'b0, 32'h01, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFD, 32'h00, 1'b0, 32'h00, 1'b0});
    vecs.push_back('{2'd3, 1'b1, 1'b0, 32'h02,       8'hFD, 32'h00, 1'b0, 32'h02, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFF, 32'h00, 1'b0, 32'h00, 1'b0});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFD, 32'h02, 1'b0, 32'h02, 1'b0});
    vecs.push_back('{2'd2, 1'b1, 1'b0, 32'h02,       8'hFD, 32'h00, 1'b1, 32'h00, 1'b1});
    vecs.push_back('{2'd0, 1'b0, 1'b1, 32'h00,       8'hFD, 32'hFD, 1'b1, 32'hFD, 1'b1});
    vecs.push_back('{2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 8'hFD, 32'h00, 1'b1, 32'h00, 1'b1});
    vecs.push_back('{2'd0, 1'b1, 1'b0, 32'h00,       8'hFD, 32'hFD, 1'b1, 32'hFD, 1'b1});
    vecs.push_back('{2'd3, 1'b0, 1'b0, 32'hFF,       8'hFD, 32'h02, 1'b1, 32'h02, 1'b1});
    vecs.push_back('{2'd2, 1'b0, 1'b1, 32'h00,       8'hFD, 32'h02, 1'b1, 32'h02, 1'b1});
    vecs.push_back('{2'd2, 1'b1, 1'b0, 32'hFFFFFF02, 8'hFD, 32'h02, 1'b1, 32'h02, 1'b1});
    vecs.push_back('{2'd2, 1'b0, 1'b1, 32'h00,       8'hFD, 32'h02, 1'b1, 32'h02, 1'b1});
    vecs.push_back('{2'd2, 1'b1, 1'b0, 32'hFF,       8'h00, 32'h02, 1'b1, 32'h02, 1'b1});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFF, 32'h02, 1'b1, 32'hFF, 1'b1});
    vecs.push_back('{2'd3, 1'b0, 1'b1, 32'h00,       8'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1});

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].a, vecs[i].cs, vecs[i].wn, vecs[i].wd, vecs[i].inp,
           vecs[i].rd0, vecs[i].irq0, vecs[i].rd2, vecs[i].irq2);

    // Asynchronous reset mid-cycle with everything set must clear outputs without a clock edge.
    #2 reset_n = 1'b0;
    #1;
    check32("midrst rd0", rd0, 32'h0);
    check1("midrst irq0", irq0, 1'b0);
    check32("midrst rd2", rd2, 32'h0);
    check1("midrst irq2", irq2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step("post mask", 2'd2, 1'b0, 1'b1, 32'h0, 8'hFF, 32'h0, 1'b0, 32'h0, 1'b0);
    step("post edge", 2'd3, 1'b0, 1'b1, 32'h0, 8'hFF, 32'h0, 1'b0, 32'h0, 1'b0);
    step("post edge2", 2'd3, 1'b0, 1'b1, 32'h0, 8'hFF, 32'h0, 1'b0, 32'h0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_irq.md
# pio_in_edge_irq

Parametrised Avalon-MM input PIO for slow status lines such as VGA vsync/hsync or push-buttons, the successor to the single-bit read-only input ports on the SoC interconnect. Samples a WIDTH-bit input bus, with optional input synchronisation. Captures configurable edges into sticky bits, cleared by writing 1 to a bit (write-1-to-clear). Raises a level interrupt to the Nios II processor when a captured edge is unmasked, so software no longer polls the frame sync.

## Interface
Parameters:
- WIDTH, 1: input bus width, legal 1..32.
- EDGE_TYPE, 0: edge captured per bit; 0 rising, 1 falling, 2 any.

Ports:
- clk  input  1  system clock; only clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select.
- chipselect  input  1  qualifies writes.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data; bits above WIDTH-1 ignored.
- in_port  input  WIDTH  external inputs, may be asynchronous.
- readdata  output  32  registered read data; bits above WIDTH-1 always 0.
- irq  output  1  level interrupt, active high.

## Operation
- Sample s: with PIO_IN_SYNC_EN, the output of a 2-flop synchroniser on in_port; without it, in_port directly.
- prev <= s every clock.
- Per-bit edge: rising s & ~prev; falling ~s & prev; any s ^ prev.
- Register map:
  - Address 0, data: read returns s. Writes are ignored.
  - Address 1: reserved. Reads 0; writes ignored.
  - Address 2, irqmask: read/write, WIDTH bits.
  - Address 3, edgecapture: read returns the sticky bits. A write (chipselect & ~write_n) clears every bit where writedata is 1.
- Reads need no chipselect: readdata <= mux(address) on every clock.
- edgecapture update per bit, when capture is enabled:
  - next = (cur & ~clr) | edge.
  - Simultaneous edge and clear on the same bit: set wins; the edge is never lost.
- irq = |(edgecapture & irqmask). Driven combinationally from registers, glitch-free.
- Prime counter: 2-bit state, reset 0, increments each clock until it reaches PRIME, then holds.
  - PRIME is 3 with PIO_IN_SYNC_EN and 1 without.
  - Capture is enabled only when count == PRIME.
  - Purpose: suppress spurious edges while the reset-zeroed pipeline fills; a line held high through reset produces no capture.
- Reset values: readdata 0, irq 0, irqmask 0, edgecapture 0, prev 0, synchroniser flops 0, prime counter 0.
- Reset asserted mid-operation clears all state immediately (asynchronous) and re-arms the prime counter.

## Timing
- in_port changes before clock edge k (no sync): edge detected in cycle k; edgecapture bit set at edge k; irq high after edge k if masked in.
- With PIO_IN_SYNC_EN: every in_port-derived event is 2 cycles later (capture at edge k+2).
- Read latency: 1 cycle. address presented in cycle n gives readdata valid after edge n.
- Write of irqmask or edgecapture takes effect at the write's clock edge; irq follows in the same cycle.
- A read of address 3 in the cycle of a clear returns the pre-clear value.

## Configuration
- PIO_IN_SYNC_EN defined:
  - 2-flop synchroniser per bit on in_port; PRIME = 3.
  - Required when in_port is asynchronous to clk (buttons, external sync lines).
- PIO_IN_SYNC_EN undefined:
  - in_port used directly; PRIME = 1; 2 cycles less latency.
  - Only for inputs already synchronous to clk, e.g. VGA controller vsync generated in the clk domain.

## Test plan
- Reset with in_port held all-ones, WIDTH=8, EDGE_TYPE=0 -> after 10 cycles edgecapture reads 0x00 and irq stays 0.
- Rising edge on bit 0 (no sync), irqmask=0x01 -> edgecapture reads 0x01 and irq rises the cycle after the edge. Write 0x01 to address 3 -> edgecapture 0x00 and irq 0 in the following cycle.
- Rising edge on bit 2 in the same cycle as a write of 0x04 to address 3 -> bit 2 remains set, edgecapture reads 0x04.
- EDGE_TYPE=2, bit 1 toggles 0->1->0 -> edgecapture 0x02 after the first toggle. With irqmask=0x00, irq stays 0; writing irqmask=0x02 raises irq in that cycle.
- PIO_IN_SYNC_EN defined, in_port=0xA5 applied -> address 0 reads 0xA5 exactly 3 cycles after the input change (2 sync + 1 read register). Reads at address 1 return 0.
- Assert reset_n low mid-operation with edgecapture=0xFF and irqmask=0xFF -> readdata, irq, irqmask and edgecapture all 0 immediately, without waiting for a clock edge.
